// File: rtl/ir_telemetry_framer.sv
`timescale 1ns/1ps
// ir_telemetry_framer
// Samples three IR line-sensor ADC channels at a fixed tick rate, thresholds
// them into a 3-bit line pattern and ships each sample to a UART as a pair of
// 32-bit frames. The second frame carries an XOR checksum over both frames.
// Ticks that arrive while a frame pair is still in flight are dropped and
// counted in a saturating overrun counter.
//
// Ports
//   clk_50      in   system clock (50 MHz)
//   rst         in   synchronous active-high reset
//   en          in   sampling enable (gates the tick counter only)
//   ir1/ir2/ir3 in   12-bit ADC readings, quasi-static
//   uart_ready  in   UART transmitter idle
//   uart_start  out  one-cycle transmit request
//   uart_data   out  word presented to the UART
//   line_pat    out  {ir3,ir2,ir1} > THRESH from the last latched sample
//   busy        out  frame pair in progress
//   overrun     out  dropped tick count, saturates at 8'hFF
module ir_telemetry_framer #(
  parameter int unsigned SAMPLE_DIV = 2500000,
  parameter logic [11:0] THRESH     = 12'd2048
) (
  input  logic        clk_50,
  input  logic        rst,
  input  logic        en,
  input  logic [11:0] ir1,
  input  logic [11:0] ir2,
  input  logic [11:0] ir3,
  input  logic        uart_ready,
  output logic        uart_start,
  output logic [31:0] uart_data,
  output logic [2:0]  line_pat,
  output logic        busy,
  output logic [7:0]  overrun
);

  localparam int unsigned CW = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [CW-1:0] TC = CW'(SAMPLE_DIV - 1);

  typedef enum logic [2:0] {
    IDLE, LATCH, SEND0, DROP0, DONE0, SEND1, DROP1, DONE1
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick;
  logic [7:0]    seq_q;
  logic [7:0]    overrun_q;
  logic [31:0]   frame0_d, frame1_d, frame1_q;
  logic [31:0]   uart_data_q;
  logic [7:0]    cs;
  logic [2:0]    line_pat_q;
  logic          uart_start_q;
  logic          busy_q;

  // Tick counter: held at zero while disabled, wraps on terminal count.
  assign tick = en && (cnt_q == TC);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (!en || tick) cnt_d = '0;
  end

  always_ff @(posedge clk_50) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  // Frame assembly from the live inputs; only sampled in LATCH.
  // The checksum uses the frame1 bytes directly from ir2/ir3 to avoid
  // a self-referencing frame1_d.
  always_comb begin
    frame0_d = {8'hA5, seq_q, 4'h0, ir1};
    cs       = frame0_d[31:24] ^ frame0_d[23:16] ^ frame0_d[15:8] ^ frame0_d[7:0]
             ^ ir2[11:4] ^ {ir2[3:0], ir3[11:8]} ^ ir3[7:0];
    frame1_d = {ir2, ir3, cs};
  end

  always_ff @(posedge clk_50) begin
    if (rst) begin
      state_q      <= IDLE;
      seq_q        <= 8'h00;
      overrun_q    <= 8'h00;
      frame1_q     <= 32'h0;
      uart_data_q  <= 32'h0;
      line_pat_q   <= 3'b000;
      uart_start_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      uart_start_q <= 1'b0;
      // Any tick not taken in IDLE is lost, including one coinciding with DONE1 exit.
      if (tick && (state_q != IDLE) && (overrun_q != 8'hFF))
        overrun_q <= overrun_q + 8'd1;
      case (state_q)
        IDLE: if (tick) begin
          state_q <= LATCH;
          busy_q  <= 1'b1;
        end
        LATCH: begin
          line_pat_q  <= {ir3 > THRESH, ir2 > THRESH, ir1 > THRESH};
          frame1_q    <= frame1_d;
          uart_data_q <= frame0_d;
          state_q     <= SEND0;
        end
        SEND0: if (uart_ready) begin
          uart_start_q <= 1'b1;
          state_q      <= DROP0;
        end
        DROP0: if (!uart_ready) state_q <= DONE0;
        DONE0: if (uart_ready) begin
          uart_data_q <= frame1_q;
          state_q     <= SEND1;
        end
        SEND1: if (uart_ready) begin
          uart_start_q <= 1'b1;
          state_q      <= DROP1;
        end
        DROP1: if (!uart_ready) state_q <= DONE1;
        DONE1: if (uart_ready) begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          seq_q   <= seq_q + 8'd1;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign uart_start = uart_start_q;
  assign uart_data  = uart_data_q;
  assign line_pat   = line_pat_q;
  assign busy       = busy_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_ir_telemetry_framer.sv
`timescale 1ns/1ps
module tb_ir_telemetry_framer;
  localparam int unsigned DIV = 16;

  logic        clk_50 = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [11:0] ir1 = '0, ir2 = '0, ir3 = '0;
  logic        uart_ready = 1'b1;
  logic        uart_start;
  logic [31:0] uart_data;
  logic [2:0]  line_pat;
  logic        busy;
  logic [7:0]  overrun;

  ir_telemetry_framer #(.SAMPLE_DIV(DIV), .THRESH(12'd2048)) dut (
    .clk_50(clk_50), .rst(rst), .en(en),
    .ir1(ir1), .ir2(ir2), .ir3(ir3),
    .uart_ready(uart_ready), .uart_start(uart_start), .uart_data(uart_data),
    .line_pat(line_pat), .busy(busy), .overrun(overrun)
  );

  initial forever #10 clk_50 = ~clk_50;

  int          tests = 0, fails = 0, starts = 0, viol = 0;
  logic [31:0] cap_q[$];
  bit          force_low = 1'b0;
  int          drop_dly = 2, busy_len = 20;
  logic [7:0]  m_seq = 8'h00;
  logic [31:0] last_f0, last_f1;

  typedef struct {
    logic [11:0] a, b, c;
    logic [2:0]  pat;
  } vec_t;
  vec_t tbl[7];

  // UART model: ready drops drop_dly cycles after a start, returns busy_len later.
  initial begin : uart_model
    int t;
    t = -1;
    forever begin
      @(negedge clk_50);
      if (uart_start === 1'b1) t = 0;
      else if (t >= 0) t++;
      if (t >= drop_dly + busy_len) t = -1;
      if (force_low) uart_ready = 1'b0;
      else uart_ready = !(t >= drop_dly && t < drop_dly + busy_len);
    end
  end

  // Start-pulse monitor: records transmitted words, flags back-to-back or idle pulses.
  initial begin : monitor
    bit prev;
    prev = 1'b0;
    forever begin
      @(negedge clk_50);
      if (uart_start === 1'b1) begin
        starts++;
        cap_q.push_back(uart_data);
        if (prev || busy !== 1'b1) viol++;
      end
      prev = (uart_start === 1'b1);
    end
  end

  initial begin : watchdog
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tmo(input string name);
    tests++;
    fails++;
    $display("FAIL %s: timeout waiting on DUT", name);
  endtask

  function automatic logic [31:0] m_f0(input logic [7:0] s, input logic [11:0] a);
    return {8'hA5, s, 4'h0, a};
  endfunction

  function automatic logic [31:0] m_f1(input logic [31:0] f0, input logic [11:0] b, input logic [11:0] c);
    logic [23:0] hi;
    logic [7:0]  x;
    hi = {b, c};
    x  = 8'h00;
    for (int k = 0; k < 4; k++) x ^= f0[8*k +: 8];
    for (int k = 0; k < 3; k++) x ^= hi[8*k +: 8];
    return {hi, x};
  endfunction

  function automatic logic [2:0] m_pat(input logic [11:0] a, input logic [11:0] b, input logic [11:0] c);
    return {c > 12'd2048, b > 12'd2048, a > 12'd2048};
  endfunction

  task automatic wait_busy(input logic lvl, input int maxc, input string name);
    int n;
    n = 0;
    while (busy !== lvl && n < maxc) begin
      @(negedge clk_50);
      n++;
    end
    if (busy !== lvl) tmo(name);
  endtask

  task automatic check_pair(input logic [11:0] a, input logic [11:0] b, input logic [11:0] c);
    logic [31:0] e0, e1;
    e0 = m_f0(m_seq, a);
    e1 = m_f1(e0, b, c);
    chk("n_starts", cap_q.size(), 2);
    if (cap_q.size() >= 2) begin
      last_f0 = cap_q[0];
      last_f1 = cap_q[1];
    end else begin
      last_f0 = 'x;
      last_f1 = 'x;
    end
    chk("frame0", last_f0, e0);
    chk("frame1", last_f1, e1);
    chk("line_pat", line_pat, m_pat(a, b, c));
    m_seq = m_seq + 8'd1;
  endtask

  task automatic run_pair(input logic [11:0] a, input logic [11:0] b, input logic [11:0] c);
    ir1 = a; ir2 = b; ir3 = c;
    cap_q.delete();
    en = 1'b1;
    wait_busy(1'b1, 4 * DIV, "tick_wait");
    en = 1'b0;
    wait_busy(1'b0, 2000, "pair_wait");
    @(negedge clk_50);
    check_pair(a, b, c);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk_50);
    rst = 1'b0;
    m_seq = 8'h00;
  endtask

  initial begin : main
    int s0, n;
    logic [11:0] a, b, c;

    tbl[0] = '{12'd2048, 12'd2049, 12'd0,    3'b010};
    tbl[1] = '{12'd2049, 12'd2048, 12'd4095, 3'b101};
    tbl[2] = '{12'd0,    12'd0,    12'd0,    3'b000};
    tbl[3] = '{12'hFFF,  12'hFFF,  12'hFFF,  3'b111};
    tbl[4] = '{12'd2049, 12'd0,    12'd2049, 3'b101};
    tbl[5] = '{12'd0,    12'd2050, 12'd2048, 3'b010};
    tbl[6] = '{12'd2048, 12'd2048, 12'd2048, 3'b000};

    repeat (3) @(negedge clk_50);
    rst = 1'b0;
    chk("rst_start", uart_start, 0);
    chk("rst_data", uart_data, 0);
    chk("rst_pat", line_pat, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovr", overrun, 0);

    // Nominal frame pair
    run_pair(12'h900, 12'h100, 12'hFFF);
    chk("nom_f0", last_f0, 32'hA5000900);
    chk("nom_f1", last_f1, 32'h100FFF4C);
    chk("nom_pat", line_pat, 3'b101);
    chk("nom_ovr", overrun, 0);

    for (int i = 0; i < 7; i++) begin
      run_pair(tbl[i].a, tbl[i].b, tbl[i].c);
      chk("tbl_pat", line_pat, tbl[i].pat);
      if (i == 0) chk("seq_after_nom", last_f0[23:16], 8'h01);
    end

    for (int i = 0; i < 20; i++) begin
      a = 12'($urandom_range(0, 4095));
      b = 12'($urandom_range(0, 4095));
      c = 12'($urandom_range(0, 4095));
      run_pair(a, b, c);
    end

    // Ready stall in SEND0
    force_low = 1'b1;
    ir1 = 12'h123; ir2 = 12'hABC; ir3 = 12'h801;
    cap_q.delete();
    s0 = starts;
    en = 1'b1;
    wait_busy(1'b1, 4 * DIV, "stall_tick");
    en = 1'b0;
    repeat (50) @(negedge clk_50);
    chk("stall_no_start", starts - s0, 0);
    chk("stall_data", uart_data, m_f0(m_seq, 12'h123));
    force_low = 1'b0;
    repeat (3) @(negedge clk_50);
    chk("stall_one_pulse", starts - s0, 1);
    wait_busy(1'b0, 2000, "stall_pair");
    @(negedge clk_50);
    check_pair(12'h123, 12'hABC, 12'h801);

    // Reset in DROP0
    ir1 = 12'hFFF; ir2 = 12'hFFF; ir3 = 12'hFFF;
    cap_q.delete();
    en = 1'b1;
    wait_busy(1'b1, 4 * DIV, "rst_tick");
    en = 1'b0;
    n = 0;
    while (uart_start !== 1'b1 && n < 200) begin
      @(negedge clk_50);
      n++;
    end
    if (uart_start !== 1'b1) tmo("rst_start_wait");
    do_reset();
    chk("midrst_start", uart_start, 0);
    chk("midrst_data", uart_data, 0);
    chk("midrst_pat", line_pat, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_ovr", overrun, 0);
    s0 = starts;
    repeat (40) @(negedge clk_50);
    chk("midrst_no_start", starts - s0, 0);
    run_pair(12'h555, 12'h0AA, 12'h900);
    chk("midrst_seq", last_f0[23:16], 8'h00);

    // Three dropped ticks while stuck in SEND0
    do_reset();
    force_low = 1'b1;
    ir1 = 12'h010; ir2 = 12'h020; ir3 = 12'h030;
    cap_q.delete();
    s0 = starts;
    en = 1'b1;
    repeat (72) @(negedge clk_50);
    en = 1'b0;
    chk("ovr3", overrun, 8'd3);
    chk("ovr3_busy", busy, 1);
    chk("ovr3_no_start", starts - s0, 0);
    force_low = 1'b0;
    wait_busy(1'b0, 2000, "ovr3_pair");
    @(negedge clk_50);
    chk("ovr3_hold", overrun, 8'd3);
    check_pair(12'h010, 12'h020, 12'h030);

    // Saturation after 300+ drops
    do_reset();
    force_low = 1'b1;
    cap_q.delete();
    en = 1'b1;
    repeat (DIV * 302) @(negedge clk_50);
    en = 1'b0;
    chk("ovr_sat", overrun, 8'hFF);
    force_low = 1'b0;
    wait_busy(1'b0, 2000, "sat_pair");
    @(negedge clk_50);
    chk("ovr_sat_hold", overrun, 8'hFF);
    check_pair(12'h010, 12'h020, 12'h030);

    // Sequence wrap
    do_reset();
    drop_dly = 1;
    busy_len = 2;
    for (int i = 0; i < 256; i++)
      run_pair(12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)));
    run_pair(12'h111, 12'h222, 12'h333);
    chk("seq_wrap", last_f0[23:16], 8'h00);

    chk("start_protocol", viol, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ir_telemetry_framer.md
IR_TELEMETRY_FRAMER -- requirements
Module: ir_telemetry_framer

Interface
REQ-001 SHALL have parameter SAMPLE_DIV, default 2500000, meaning clk_50 cycles per sample tick (20 Hz at 50 MHz); legal range 16..2^24.
REQ-002 SHALL have parameter THRESH, default 12'd2048, meaning the line-detect threshold applied to each IR channel.
REQ-003 clk_50  input  1  system clock, 50 MHz; the block has one clock.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 en  input  1  sampling enable.
REQ-006 ir1, ir2, ir3  input  12 each  ADC channel 5/6/7 readings; free-running and treated as quasi-static.
REQ-007 uart_ready  input  1  UART transmitter idle flag.
REQ-008 uart_start  output  1  one-cycle transmit request to the UART.
REQ-009 uart_data  output  32  word presented to the UART.
REQ-010 line_pat  output  3  thresholded pattern {ir3,ir2,ir1} from the last latched sample.
REQ-011 busy  output  1  high while a frame pair is in progress.
REQ-012 overrun  output  8  count of dropped sample ticks; saturates at 8'hFF.

Function
REQ-013 Tick counter SHALL count 0..SAMPLE_DIV-1 while en=1 and hold at 0 while en=0.
REQ-014 A tick SHALL occur on the cycle the counter equals SAMPLE_DIV-1; the counter then wraps to 0.
REQ-015 FSM states SHALL be IDLE, LATCH, SEND0, DROP0, DONE0, SEND1, DROP1, DONE1.
REQ-016 In IDLE, a tick SHALL move the FSM to LATCH on the next cycle.
REQ-017 In LATCH (one cycle), the block SHALL capture ir1/ir2/ir3.
REQ-018 In LATCH, the block SHALL update line_pat[i] = (irN > THRESH), using strict greater-than.
REQ-019 In LATCH, the block SHALL build frame0 = {8'hA5, seq[7:0], 4'h0, ir1}.
REQ-020 In LATCH, the block SHALL build frame1 = {ir2, ir3, cs}, where cs = XOR of bytes 3..0 of frame0 and bytes 3..1 of frame1.
REQ-021 LATCH SHALL always go to SEND0.
REQ-022 SENDx SHALL drive uart_data = framex and hold it constant until DONEx exits.
REQ-023 SENDx SHALL assert uart_start for exactly one cycle, in the first cycle of SENDx with uart_ready=1, then go to DROPx.
REQ-024 SENDx SHALL wait with uart_start=0 while uart_ready=0.
REQ-025 DROPx SHALL wait for uart_ready=0, then go to DONEx.
REQ-026 DONEx SHALL wait for uart_ready=1; DONE0 then goes to SEND1, and DONE1 goes to IDLE.
REQ-027 On DONE1 exit, seq SHALL increment by 1 and wrap from 8'hFF to 8'h00.
REQ-028 uart_start SHALL never be asserted outside SEND0/SEND1, and never twice per state visit.
REQ-029 busy SHALL be 1 in every state except IDLE.
REQ-030 A tick arriving while state != IDLE SHALL be dropped and SHALL increment overrun; overrun holds at 8'hFF.
REQ-031 Deasserting en mid-frame SHALL NOT abort the frame pair in progress; it only stops new ticks.
REQ-032 A tick and a DONE1 exit in the same cycle SHALL count as an overrun (state != IDLE that cycle).
REQ-033 uart_data SHALL hold its last value while in IDLE.

Reset
REQ-034 When rst=1 at a clk_50 edge, the block SHALL force: FSM=IDLE, tick counter=0, seq=0, uart_start=0, uart_data=0, line_pat=0, busy=0, overrun=0.
REQ-035 Reset SHALL take precedence over all other inputs.
REQ-036 A reset asserted mid-frame SHALL abandon the frame with no further uart_start.

Verification
REQ-037 SHALL cover nominal frame: SAMPLE_DIV=16, en=1, ir1=12'h900, ir2=12'h100, ir3=12'hFFF, seq=0, UART model drops ready 2 cycles after start and raises it after 20 -> uart_data=32'hA5000900 then 32'h100FFF4C, one start pulse each, line_pat=3'b101, seq=1.
REQ-038 SHALL cover threshold boundary: ir1=12'd2048, ir2=12'd2049, ir3=0 -> line_pat=3'b010.
REQ-039 SHALL cover ready stall: uart_ready held 0 for 50 cycles at SEND0 -> uart_start=0 throughout, a single pulse on the first ready=1 cycle, and uart_data stable.
REQ-040 SHALL cover overrun: UART holds ready low for 3*SAMPLE_DIV cycles -> overrun=3, and busy remains 1 until DONE1 exit; also force 300 drops -> overrun=8'hFF.
REQ-041 SHALL cover seq wrap: 256 completed frame pairs -> frame0[23:16] returns to 8'h00.
REQ-042 SHALL cover reset mid-frame: rst pulse in DROP0 -> all outputs 0 the next cycle, no uart_start until the next tick, and seq=0.
